// File: rtl/phase_sequencer.sv
// Purpose: multicycle IF/DE/EX/WB phase sequencer with run/step/stop debug control, PC breakpoint and retire counter.
// Latency: run/step reaches IF one cycle after the command edge; an unstalled instruction takes 4 cycles.
// Backpressure: mem_busy stretches IF (always) and WB (memory ops only); WAIT_MAX consecutive stalls abort to HALT.
module phase_sequencer #(
  parameter int unsigned WAIT_MAX      = 15,
  parameter bit          START_RUNNING = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        stop,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc_next,
  input  logic        mem_access,
  input  logic        mem_busy,
  output logic [3:0]  cstate,
  output logic        running,
  output logic        bp_hit,
  output logic        timeout,
  output logic        retire,
  output logic [31:0] icount
);

  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_IF   = 3'd1,
    ST_DE   = 3'd2,
    ST_EX   = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // Stall limit as an 8-bit value; WAIT_MAX is confined to 1..255.
  localparam logic [7:0] WAIT_LIM    = 8'(WAIT_MAX);
  localparam state_t     RESET_STATE = START_RUNNING ? ST_IF : ST_HALT;

  state_t      state,     state_nxt;
  logic [31:0] icount_nxt;
  logic        bp_hit_nxt;
  logic        timeout_nxt;
  logic        retire_nxt;
  logic        stop_pend, stop_pend_nxt;
  logic        step_mode, step_mode_nxt;
  logic        skip_bp,   skip_bp_nxt;
  logic [7:0]  wait_cnt,  wait_cnt_nxt;

  logic [7:0]  wait_inc;
  logic        stall;
  logic        bp_match;

  // Breakpoint compare on the address of the instruction about to be fetched.
  assign bp_match = bp_en && (pc_next == bp_addr) && !skip_bp;

  // State and bookkeeping registers; reset abandons any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RESET_STATE;
      icount    <= 32'd0;
      bp_hit    <= 1'b0;
      timeout   <= 1'b0;
      retire    <= 1'b0;
      stop_pend <= 1'b0;
      step_mode <= 1'b0;
      skip_bp   <= 1'b0;
      wait_cnt  <= 8'd0;
    end else begin
      state     <= state_nxt;
      icount    <= icount_nxt;
      bp_hit    <= bp_hit_nxt;
      timeout   <= timeout_nxt;
      retire    <= retire_nxt;
      stop_pend <= stop_pend_nxt;
      step_mode <= step_mode_nxt;
      skip_bp   <= skip_bp_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  // Next-state, stall/timeout handling and debug command decoding.
  always_comb begin
    state_nxt     = state;
    icount_nxt    = icount;
    bp_hit_nxt    = bp_hit;
    timeout_nxt   = timeout;
    retire_nxt    = 1'b0;
    stop_pend_nxt = stop_pend;
    step_mode_nxt = step_mode;
    skip_bp_nxt   = skip_bp;
    wait_cnt_nxt  = 8'd0;
    wait_inc      = wait_cnt + 8'd1;
    stall         = 1'b0;

    case (state)
      ST_HALT: begin
        // step wins over run; either one starts a fresh instruction and
        // arms skip_bp so resuming on a breakpoint address does not re-halt.
        if (step || run) begin
          state_nxt     = ST_IF;
          step_mode_nxt = step;
          bp_hit_nxt    = 1'b0;
          timeout_nxt   = 1'b0;
          skip_bp_nxt   = 1'b1;
        end
      end

      ST_IF: begin
        stall = mem_busy;
        if (!mem_busy) begin
          state_nxt = ST_DE;
        end
      end

      ST_DE: begin
        state_nxt = ST_EX;
      end

      ST_EX: begin
        state_nxt = ST_WB;
      end

      ST_WB: begin
        stall = mem_access && mem_busy;
        if (!stall) begin
          // Instruction boundary: retire and pick the next phase.
          retire_nxt    = 1'b1;
          icount_nxt    = icount + 32'd1;
          stop_pend_nxt = 1'b0;
          skip_bp_nxt   = 1'b0;
          if (stop_pend || step_mode) begin
            state_nxt = ST_HALT;
          end else if (bp_match) begin
            state_nxt  = ST_HALT;
            bp_hit_nxt = 1'b1;
          end else begin
            state_nxt = ST_IF;
          end
        end
      end

      default: begin
        state_nxt = ST_HALT;
      end
    endcase

    // Consecutive-stall counter; it restarts from zero whenever the phase
    // advances, so the limit applies per phase rather than per instruction.
    if (stall) begin
      if (wait_inc == WAIT_LIM) begin
        state_nxt    = ST_HALT;
        timeout_nxt  = 1'b1;
        wait_cnt_nxt = 8'd0;
      end else begin
        wait_cnt_nxt = wait_inc;
      end
    end

    // A stop seen on a completion edge survives the clear above and halts
    // at the following boundary instead.
    if ((state != ST_HALT) && stop) begin
      stop_pend_nxt = 1'b1;
    end
  end

  // One-hot phase decode straight from the state register.
  always_comb begin
    cstate = 4'b0000;
    case (state)
      ST_IF:   cstate = 4'b0001;
      ST_DE:   cstate = 4'b0010;
      ST_EX:   cstate = 4'b0100;
      ST_WB:   cstate = 4'b1000;
      default: cstate = 4'b0000;
    endcase
  end

  assign running = (state != ST_HALT);

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  localparam logic [3:0] C_HALT = 4'b0000;
  localparam logic [3:0] C_IF   = 4'b0001;
  localparam logic [3:0] C_DE   = 4'b0010;
  localparam logic [3:0] C_EX   = 4'b0100;
  localparam logic [3:0] C_WB   = 4'b1000;

  logic        clock;
  logic        reset;
  logic        run;
  logic        step;
  logic        stop;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_next;
  logic        mem_access;
  logic        mem_busy;
  logic [3:0]  cstate;
  logic        running;
  logic        bp_hit;
  logic        timeout;
  logic        retire;
  logic [31:0] icount;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_icount = 32'd0;

  phase_sequencer #(
    .WAIT_MAX      (15),
    .START_RUNNING (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .stop       (stop),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc_next    (pc_next),
    .mem_access (mem_access),
    .mem_busy   (mem_busy),
    .cstate     (cstate),
    .running    (running),
    .bp_hit     (bp_hit),
    .timeout    (timeout),
    .retire     (retire),
    .icount     (icount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  // Counts cycles until cstate reads halted, bounded.
  task automatic wait_halt(output int n);
    n = 0;
    while (cstate !== C_HALT && n < 60) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (cstate !== C_HALT) begin errors++; $display("FAIL reset_cstate got %b want %b", cstate, C_HALT); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (icount !== 32'd0) begin errors++; $display("FAIL reset_icount got %0d want 0", icount); end
    checks++; if ({bp_hit, timeout, retire} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bp_hit, timeout, retire}); end
    reset = 1'b0;
    tick();
    checks++; if (cstate !== C_HALT) begin errors++; $display("FAIL reset_stays_halted got %b want %b", cstate, C_HALT); end
  endtask

  task automatic test_single_step();
    logic [3:0] seq [5];
    seq[0] = C_IF; seq[1] = C_DE; seq[2] = C_EX; seq[3] = C_WB; seq[4] = C_HALT;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (cstate !== seq[i]) begin errors++; $display("FAIL step_seq[%0d] got %b want %b", i, cstate, seq[i]); end
      checks++; if (retire !== (i == 4)) begin errors++; $display("FAIL step_retire[%0d] got %b want %b", i, retire, (i == 4)); end
      if (i < 4) tick();
    end
    exp_icount = exp_icount + 32'd1;
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL step_icount got %0d want %0d", icount, exp_icount); end
    tick();
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL step_retire_pulse got %b want 0", retire); end
  endtask

  task automatic test_if_stall();
    int n;
    int if_cycles;
    mem_busy = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    stop = 1'b1;
    n = 0;
    if_cycles = 0;
    while (cstate !== C_HALT && n < 40) begin
      if (cstate === C_IF) if_cycles++;
      n++;
      tick();
      stop = 1'b0;
      if (n == 3) mem_busy = 1'b0;
    end
    exp_icount = exp_icount + 32'd1;
    checks++; if (if_cycles !== 4) begin errors++; $display("FAIL if_stall_if_cycles got %0d want 4", if_cycles); end
    checks++; if (n !== 7) begin errors++; $display("FAIL if_stall_total_cycles got %0d want 7", n); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL if_stall_timeout got %b want 0", timeout); end
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL if_stall_icount got %0d want %0d", icount, exp_icount); end
    tick();
  endtask

  task automatic test_wb_timeout();
    int n;
    mem_access = 1'b1;
    mem_busy = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();                      // DE
    mem_busy = 1'b1;
    tick();                      // EX
    tick();                      // WB
    checks++; if (cstate !== C_WB) begin errors++; $display("FAIL timeout_in_wb got %b want %b", cstate, C_WB); end
    n = 0;
    while (cstate === C_WB && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL timeout_wb_cycles got %0d want 15", n); end
    checks++; if (cstate !== C_HALT) begin errors++; $display("FAIL timeout_halted got %b want %b", cstate, C_HALT); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b want 1", timeout); end
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL timeout_icount got %0d want %0d", icount, exp_icount); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL timeout_retire got %b want 0", retire); end
    mem_busy = 1'b0;
    mem_access = 1'b0;
    tick();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", timeout); end
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_cleared_by_run got %b want 0", timeout); end
    checks++; if (cstate !== C_IF) begin errors++; $display("FAIL timeout_resume_if got %b want %b", cstate, C_IF); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_halt(n);
    exp_icount = exp_icount + 32'd1;
    checks++; if (n !== 3) begin errors++; $display("FAIL timeout_resume_cycles got %0d want 3", n); end
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL timeout_resume_icount got %0d want %0d", icount, exp_icount); end
    tick();
  endtask

  task automatic test_breakpoint();
    int n;
    bp_en = 1'b1;
    bp_addr = 32'h0000_0010;
    pc_next = 32'h0000_0010;
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_halt(n);
    exp_icount = exp_icount + 32'd2;
    checks++; if (n !== 8) begin errors++; $display("FAIL bp_halt_cycles got %0d want 8", n); end
    checks++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit_set got %b want 1", bp_hit); end
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL bp_icount got %0d want %0d", icount, exp_icount); end
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_hit_cleared got %b want 0", bp_hit); end
    tick(); tick(); tick(); tick();
    checks++; if (cstate !== C_IF) begin errors++; $display("FAIL bp_no_rehalt got %b want %b", cstate, C_IF); end
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL bp_resume_retire got %b want 1", retire); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_halt(n);
    exp_icount = exp_icount + 32'd2;
    checks++; if (n !== 3) begin errors++; $display("FAIL bp_stop_cycles got %0d want 3", n); end
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_stop_priority got %b want 0", bp_hit); end
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL bp_resume_icount got %0d want %0d", icount, exp_icount); end
    bp_en = 1'b0;
    pc_next = 32'h0000_0000;
    tick();
  endtask

  task automatic test_stop();
    int n;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    checks++; if (cstate !== C_EX) begin errors++; $display("FAIL stop_ex_phase got %b want %b", cstate, C_EX); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (cstate !== C_WB) begin errors++; $display("FAIL stop_ex_wb got %b want %b", cstate, C_WB); end
    tick();
    exp_icount = exp_icount + 32'd1;
    checks++; if (cstate !== C_HALT) begin errors++; $display("FAIL stop_ex_halt got %b want %b", cstate, C_HALT); end
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL stop_ex_retire got %b want 1", retire); end
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick();
    checks++; if (cstate !== C_WB) begin errors++; $display("FAIL stop_edge_wb got %b want %b", cstate, C_WB); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (cstate !== C_IF) begin errors++; $display("FAIL stop_edge_continues got %b want %b", cstate, C_IF); end
    wait_halt(n);
    exp_icount = exp_icount + 32'd2;
    checks++; if (n !== 4) begin errors++; $display("FAIL stop_edge_cycles got %0d want 4", n); end
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL stop_icount got %0d want %0d", icount, exp_icount); end
    tick();
  endtask

  task automatic test_cmd_priority();
    int n;
    step = 1'b1;
    run = 1'b1;
    tick();
    step = 1'b0;
    run = 1'b0;
    wait_halt(n);
    exp_icount = exp_icount + 32'd1;
    checks++; if (n !== 4) begin errors++; $display("FAIL prio_step_cycles got %0d want 4", n); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (cstate !== C_HALT) begin errors++; $display("FAIL prio_stop_in_halt got %b want %b", cstate, C_HALT); end
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (cstate !== C_IF) begin errors++; $display("FAIL prio_stop_ignored got %b want %b", cstate, C_IF); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_halt(n);
    exp_icount = exp_icount + 32'd2;
    checks++; if (n !== 3) begin errors++; $display("FAIL prio_run_stop_cycles got %0d want 3", n); end
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL prio_icount got %0d want %0d", icount, exp_icount); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    mem_access = 1'b1;
    mem_busy = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    mem_busy = 1'b1;
    tick();
    tick();
    tick();
    tick();
    checks++; if (cstate !== C_WB) begin errors++; $display("FAIL rst_stall_in_wb got %b want %b", cstate, C_WB); end
    checks++; if (icount !== exp_icount) begin errors++; $display("FAIL rst_pre_icount got %0d want %0d", icount, exp_icount); end
    reset = 1'b1;
    tick();
    checks++; if (cstate !== C_HALT) begin errors++; $display("FAIL rst_stall_cstate got %b want %b", cstate, C_HALT); end
    checks++; if (icount !== 32'd0) begin errors++; $display("FAIL rst_stall_icount got %0d want 0", icount); end
    checks++; if ({bp_hit, timeout, retire, running} !== 4'b0000) begin errors++; $display("FAIL rst_stall_flags got %b want 0000", {bp_hit, timeout, retire, running}); end
    reset = 1'b0;
    mem_busy = 1'b0;
    mem_access = 1'b0;
    tick();
    tick();
    checks++; if (cstate !== C_HALT) begin errors++; $display("FAIL rst_stall_after got %b want %b", cstate, C_HALT); end
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    step = 1'b0;
    stop = 1'b0;
    bp_en = 1'b0;
    bp_addr = 32'd0;
    pc_next = 32'd0;
    mem_access = 1'b0;
    mem_busy = 1'b0;

    test_reset();
    test_single_step();
    test_if_stall();
    test_wb_timeout();
    test_breakpoint();
    test_stop();
    test_cmd_priority();
    test_reset_mid_stall();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Multicycle phase sequencer for the core. It generates the one-hot phase vector `cstate` (IF/DE/EX/WB) that drives the combinational controller, and stretches the IF and memory-WB phases while memory is busy. It also provides run/step/stop debug control, a single PC breakpoint and a retired-instruction counter. It sits between the host/debug interface, the memory system and the controller.

## Interface
- `WAIT_MAX`, default 15: consecutive busy cycles in one phase before aborting with timeout (1..255).
- `START_RUNNING`, default 0: 1 means execution starts in IF out of reset; 0 means it starts halted.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  one-cycle pulse: resume continuous execution from HALT.
- `step`  in  1  one-cycle pulse: execute exactly one instruction from HALT.
- `stop`  in  1  one-cycle pulse: halt at the next instruction boundary.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  32  breakpoint instruction address.
- `pc_next`  in  32  address of the next instruction (PC mux output); valid in the final WB cycle.
- `mem_access`  in  1  current instruction uses memory in WB (load/store); decoded from IR.
- `mem_busy`  in  1  memory not ready this cycle.
- `cstate`  out  4  phase: 0001 IF, 0010 DE, 0100 EX, 1000 WB, 0000 halted.
- `running`  out  1  1 whenever cstate is nonzero.
- `bp_hit`  out  1  sticky: the last halt was caused by the breakpoint.
- `timeout`  out  1  sticky: the last halt was caused by a memory timeout.
- `retire`  out  1  one-cycle pulse on the WB completion edge.
- `icount`  out  32  retired instruction count.

## Operation
- States: HALT, IF, DE, EX, WB. `cstate` decodes the state directly.
- Reset (synchronous, active-high):
  - state = IF if START_RUNNING=1, else HALT.
  - icount=0, bp_hit=0, timeout=0, retire=0.
  - stop_pend=0, step_mode=0, skip_bp=0, wait_cnt=0.
- HALT:
  - step → IF, step_mode=1.
  - Else run → IF, step_mode=0.
  - step has priority over run when both are asserted.
  - Either command clears bp_hit and timeout, and sets skip_bp=1.
  - stop is ignored in HALT.
- DE and EX always last exactly 1 cycle: IF→DE→EX→WB.
- IF stalls while mem_busy=1. WB stalls while mem_access=1 and mem_busy=1.
  - wait_cnt counts consecutive stalled cycles and is cleared whenever the phase advances.
  - The phase advances on the first cycle busy is low.
- Timeout: when a stalled cycle would make wait_cnt reach WAIT_MAX, the next state is HALT and timeout=1.
  - No retire and no icount increment.
  - The instruction is abandoned.
- WB completion (final non-stalled WB cycle):
  - retire=1 for the following cycle; icount += 1, wrapping modulo 2^32.
  - Next state, in priority order:
    - HALT if stop_pend or step_mode.
    - HALT with bp_hit=1 if bp_en, pc_next==bp_addr, and skip_bp=0.
    - IF otherwise.
  - stop_pend and skip_bp clear at every WB completion.
- stop while not halted sets stop_pend, including when it coincides with a WB completion edge; that case halts at the following boundary.
- run and step while not halted are ignored.
- skip_bp suppresses the breakpoint only for the first instruction after resume, so resuming at a breakpoint address never re-halts immediately.
- Reset mid-instruction or mid-stall: abandon immediately and take reset values on that edge.

## Timing
- run/step sampled at edge t gives cstate=0001 during cycle t+1.
- Unstalled instruction: 4 cycles, IF→WB. Each stall cycle adds 1.
- retire is high in the cycle after the WB completion edge, concurrent with the next IF or with HALT. icount updates on the same edge.
- stop latency: halt at the first WB completion after the edge on which stop is sampled; cstate=0000 the cycle after that WB.
- Timeout halt: cstate=0000 in the cycle after the WAIT_MAX-th stalled cycle.
- All outputs are registered, or decoded from registered state only; there is no combinational path from inputs to outputs.

## Test plan
- Reset with START_RUNNING=0, pulse step, mem_busy=0 → cstate 0001,0010,0100,1000,0000 on consecutive cycles; retire pulses once; icount=1.
- Run with mem_busy=1 for 3 cycles in IF → IF held 4 cycles; instruction takes 7 cycles; timeout=0.
- mem_access=1 with mem_busy stuck high in WB, WAIT_MAX=15 → halt after 15 stalled cycles; timeout=1; icount unchanged; a following run clears timeout.
- bp_en=1, bp_addr=0x10, program reaches pc_next=0x10 → halt with bp_hit=1. A following run executes the instruction at 0x10 without re-halting, and bp_hit clears.
- Run, then stop asserted during EX → halt after that WB. Stop pulsed exactly on a WB completion edge → halt after the next WB.
- Reset asserted mid-WB-stall → next cycle cstate=0000, icount=0, all sticky flags 0.
